// File: rtl/exec_controller.sv
// Execution sequencer for proc_memory: turns the 50 MHz clock into a one-cycle
// processor enable and supports free run, single-instruction step and PC breakpoints.
module exec_controller #(
    parameter int unsigned DIV_COUNT   = 5000000,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [3:0]  TICK_IDLE   = 4'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        run_sw,
    input  logic        step_key_n,
    input  logic        bp_en,
    input  logic [15:0] bp_addr,
    input  logic [15:0] pc,
    input  logic [3:0]  tick,
    output logic        proc_en,
    output logic [1:0]  state,
    output logic        halted,
    output logic [15:0] instr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        STEP = 2'd2,
        HALT = 2'd3
    } state_t;

    localparam int unsigned      CNT_W   = $clog2(DIV_COUNT);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_COUNT - 1);

    state_t                 state_q;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   key_prev;
    logic                   step_req;
    logic                   pulse_d;
    logic [3:0]             tick_at_pulse;
    logic                   retire;
    logic                   bp_hit;
    logic                   active_nxt;
    logic                   proc_en_nxt;
    logic [15:0]            count_nxt;

    // Key synchroniser plus one extra flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '1;
            key_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking so every flop samples the pre-edge value of its neighbour.
            sync_q   <= {sync_q[SYNC_STAGES-2:0], step_key_n};
            key_prev <= sync_q[SYNC_STAGES-1];
        end
    end

    assign step_req = key_prev & ~sync_q[SYNC_STAGES-1];

    // An instruction retires when the pulse just moved tick back to the idle value.
    assign retire = pulse_d && (tick_at_pulse != TICK_IDLE) && (tick == TICK_IDLE);
    assign bp_hit = bp_en && (pc == bp_addr);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        // NOTE: default first so the unassigned paths hold state instead of inferring a latch.
        state_nxt = state_q;
        unique case (state_q)
            IDLE: begin
                if (run_sw) begin
                    state_nxt = RUN;
                end else if (step_req) begin
                    state_nxt = STEP;
                end
            end
            RUN: begin
                if (!run_sw) begin
                    state_nxt = IDLE;
                end else if (retire && bp_hit) begin
                    state_nxt = HALT;
                end
            end
            STEP: begin
                if (retire) begin
                    state_nxt = run_sw ? HALT : IDLE;
                end
            end
            HALT: begin
                if (!run_sw) begin
                    state_nxt = IDLE;
                end else if (step_req) begin
                    state_nxt = STEP;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        halted     = (state_q == HALT);
        active_nxt = (state_nxt == RUN) || (state_nxt == STEP);

        // The counter restarts on every entry so the first pulse is a full period away.
        if (!active_nxt || (state_nxt != state_q)) begin
            cnt_nxt = '0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_nxt = '0;
        end else begin
            cnt_nxt = cnt_q + 1'b1;
        end

        proc_en_nxt = active_nxt && (state_nxt == state_q) && (cnt_q == CNT_MAX);
        count_nxt   = retire ? instr_count + 16'd1 : instr_count;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            proc_en       <= 1'b0;
            pulse_d       <= 1'b0;
            tick_at_pulse <= '0;
            instr_count   <= '0;
        end else begin
            cnt_q       <= cnt_nxt;
            proc_en     <= proc_en_nxt;
            pulse_d     <= proc_en;
            instr_count <= count_nxt;
            if (proc_en) begin
                tick_at_pulse <= tick;
            end
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_exec_controller.sv
// Directed bench for exec_controller with a small processor model that advances
// tick 0..3 on each proc_en and adds 2 to pc whenever tick wraps to 0.
module tb_exec_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        run_sw = 1'b0;
    logic        step_key_n = 1'b1;
    logic        bp_en = 1'b0;
    logic [15:0] bp_addr = 16'h0000;
    logic [15:0] pc = 16'h0000;
    logic [3:0]  tick = 4'd0;
    logic        proc_en;
    logic [1:0]  state;
    logic        halted;
    logic [15:0] instr_count;

    int   total = 0;
    int   bad = 0;
    int   pulses = 0;
    int   cyc_n = 0;
    logic en_seen = 1'b0;

    exec_controller #(
        .DIV_COUNT  (4),
        .SYNC_STAGES(2),
        .TICK_IDLE  (4'd0)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run_sw     (run_sw),
        .step_key_n (step_key_n),
        .bp_en      (bp_en),
        .bp_addr    (bp_addr),
        .pc         (pc),
        .tick       (tick),
        .proc_en    (proc_en),
        .state      (state),
        .halted     (halted),
        .instr_count(instr_count)
    );

    always #10 clk = ~clk;

    // One clock: sample proc_en mid-cycle, then advance the processor model just after the edge.
    task automatic cyc();
        @(negedge clk);
        en_seen = proc_en;
        if (proc_en === 1'b1) pulses++;
        @(posedge clk);
        #1;
        cyc_n++;
        if (en_seen === 1'b1) begin
            if (tick == 4'd3) begin
                pc   = pc + 16'd2;
                tick = 4'd0;
            end else begin
                tick = tick + 4'd1;
            end
        end
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        run_sw     = 1'b0;
        step_key_n = 1'b1;
        bp_en      = 1'b0;
        bp_addr    = 16'h0000;
        cyc();
        cyc();
        rst    = 1'b0;
        pc     = 16'h0000;
        tick   = 4'd0;
        pulses = 0;
    endtask

    task automatic test_reset();
        int first_at;
        rst        = 1'b1;
        run_sw     = 1'b1;
        step_key_n = 1'b1;
        cyc();
        cyc();
        total++; if (proc_en !== 1'b0) begin bad++; $display("FAIL reset_proc_en: got %b want 0", proc_en); end
        total++; if (state !== 2'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
        total++; if (halted !== 1'b0) begin bad++; $display("FAIL reset_halted: got %b want 0", halted); end
        total++; if (instr_count !== 16'd0) begin bad++; $display("FAIL reset_count: got %0d want 0", instr_count); end
        rst  = 1'b0;
        pc   = 16'h0000;
        tick = 4'd0;
        cyc();
        total++; if (state !== 2'd1) begin bad++; $display("FAIL reset_release_state: got %0d want 1", state); end
        first_at = 0;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            if (proc_en === 1'b1 && first_at == 0) first_at = i;
        end
        total++; if (first_at !== 4) begin bad++; $display("FAIL reset_first_pulse: got cycle %0d want 4", first_at); end
    endtask

    task automatic test_free_run();
        int last;
        int gap_bad;
        do_reset();
        run_sw  = 1'b1;
        last    = -1;
        gap_bad = 0;
        for (int i = 0; i < 200 && pulses < 16; i++) begin
            cyc();
            if (en_seen === 1'b1) begin
                if (last >= 0 && (cyc_n - last) != 4) gap_bad++;
                last = cyc_n;
            end
        end
        total++; if (pulses !== 16) begin bad++; $display("FAIL free_run_pulses: got %0d want 16", pulses); end
        total++; if (gap_bad !== 0) begin bad++; $display("FAIL free_run_period: got %0d bad gaps want 0", gap_bad); end
        cyc();
        total++; if (instr_count !== 16'd4) begin bad++; $display("FAIL free_run_count: got %0d want 4", instr_count); end
        total++; if (pc !== 16'h0008) begin bad++; $display("FAIL free_run_pc: got %h want 0008", pc); end
        total++; if (state !== 2'd1) begin bad++; $display("FAIL free_run_state: got %0d want 1", state); end
    endtask

    task automatic test_single_step();
        do_reset();
        step_key_n = 1'b0;
        repeat (10) cyc();
        total++; if (state !== 2'd2) begin bad++; $display("FAIL step_state_mid: got %0d want 2", state); end
        repeat (30) cyc();
        total++; if (pulses !== 4) begin bad++; $display("FAIL step_pulses: got %0d want 4", pulses); end
        total++; if (instr_count !== 16'd1) begin bad++; $display("FAIL step_count: got %0d want 1", instr_count); end
        total++; if (state !== 2'd0) begin bad++; $display("FAIL step_state_end: got %0d want 0", state); end
        total++; if (tick !== 4'd0) begin bad++; $display("FAIL step_tick: got %0d want 0", tick); end
        step_key_n = 1'b1;
        repeat (5) cyc();
        pulses     = 0;
        step_key_n = 1'b0;
        repeat (30) cyc();
        total++; if (pulses !== 4) begin bad++; $display("FAIL step2_pulses: got %0d want 4", pulses); end
        total++; if (instr_count !== 16'd2) begin bad++; $display("FAIL step2_count: got %0d want 2", instr_count); end
        total++; if (pc !== 16'h0004) begin bad++; $display("FAIL step2_pc: got %h want 0004", pc); end
        step_key_n = 1'b1;
    endtask

    task automatic test_breakpoint();
        do_reset();
        bp_en   = 1'b1;
        bp_addr = 16'h0006;
        run_sw  = 1'b1;
        for (int i = 0; i < 300 && halted !== 1'b1; i++) cyc();
        total++; if (state !== 2'd3) begin bad++; $display("FAIL bp_state: got %0d want 3", state); end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL bp_halted: got %b want 1", halted); end
        total++; if (pc !== 16'h0006) begin bad++; $display("FAIL bp_pc: got %h want 0006", pc); end
        total++; if (instr_count !== 16'd3) begin bad++; $display("FAIL bp_count: got %0d want 3", instr_count); end
        pulses = 0;
        repeat (100) cyc();
        total++; if (pulses !== 0) begin bad++; $display("FAIL bp_quiet: got %0d pulses want 0", pulses); end
        step_key_n = 1'b0;
        repeat (40) cyc();
        total++; if (pc !== 16'h0008) begin bad++; $display("FAIL bp_step_pc: got %h want 0008", pc); end
        total++; if (instr_count !== 16'd4) begin bad++; $display("FAIL bp_step_count: got %0d want 4", instr_count); end
        total++; if (state !== 2'd3) begin bad++; $display("FAIL bp_step_state: got %0d want 3", state); end
        step_key_n = 1'b1;
        repeat (3) cyc();
        run_sw = 1'b0;
        cyc();
        total++; if (state !== 2'd0) begin bad++; $display("FAIL bp_resume_idle: got %0d want 0", state); end
        run_sw = 1'b1;
        cyc();
        total++; if (state !== 2'd1) begin bad++; $display("FAIL bp_resume_run: got %0d want 1", state); end
        pulses = 0;
        repeat (9) cyc();
        total++; if (pulses !== 2) begin bad++; $display("FAIL bp_resume_pulses: got %0d want 2", pulses); end
    endtask

    task automatic test_abort();
        do_reset();
        run_sw = 1'b1;
        for (int i = 0; i < 100 && tick != 4'd2; i++) cyc();
        run_sw = 1'b0;
        cyc();
        total++; if (state !== 2'd0) begin bad++; $display("FAIL abort_state: got %0d want 0", state); end
        total++; if (proc_en !== 1'b0) begin bad++; $display("FAIL abort_proc_en: got %b want 0", proc_en); end
        pulses = 0;
        repeat (12) cyc();
        total++; if (pulses !== 0) begin bad++; $display("FAIL abort_quiet: got %0d pulses want 0", pulses); end
        total++; if (tick !== 4'd2) begin bad++; $display("FAIL abort_tick_paused: got %0d want 2", tick); end
        step_key_n = 1'b0;
        repeat (30) cyc();
        total++; if (pulses !== 2) begin bad++; $display("FAIL abort_step_pulses: got %0d want 2", pulses); end
        total++; if (tick !== 4'd0) begin bad++; $display("FAIL abort_step_tick: got %0d want 0", tick); end
        total++; if (instr_count !== 16'd1) begin bad++; $display("FAIL abort_step_count: got %0d want 1", instr_count); end
        total++; if (state !== 2'd0) begin bad++; $display("FAIL abort_step_state: got %0d want 0", state); end
        step_key_n = 1'b1;
    endtask

    task automatic test_reset_mid_run();
        int first_at;
        do_reset();
        run_sw = 1'b1;
        cyc();
        repeat (3) cyc();
        rst = 1'b1;
        cyc();
        total++; if (proc_en !== 1'b0) begin bad++; $display("FAIL midrst_proc_en: got %b want 0", proc_en); end
        total++; if (state !== 2'd0) begin bad++; $display("FAIL midrst_state: got %0d want 0", state); end
        rst    = 1'b0;
        pulses = 0;
        cyc();
        total++; if (pulses !== 0) begin bad++; $display("FAIL midrst_no_pulse: got %0d want 0", pulses); end
        total++; if (state !== 2'd1) begin bad++; $display("FAIL midrst_rerun: got %0d want 1", state); end
        first_at = 0;
        for (int i = 1; i <= 6; i++) begin
            cyc();
            if (proc_en === 1'b1 && first_at == 0) first_at = i;
        end
        total++; if (first_at !== 4) begin bad++; $display("FAIL midrst_first_pulse: got cycle %0d want 4", first_at); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        step_key_n = 1'b0;
        cyc();
        cyc();
        run_sw = 1'b1;
        cyc();
        total++; if (state !== 2'd1) begin bad++; $display("FAIL idle_run_beats_step: got %0d want 1", state); end
        step_key_n = 1'b1;
        for (int i = 0; i < 100 && pulses < 4; i++) cyc();
        run_sw = 1'b0;
        cyc();
        total++; if (state !== 2'd0) begin bad++; $display("FAIL retire_drop_state: got %0d want 0", state); end
        total++; if (instr_count !== 16'd1) begin bad++; $display("FAIL retire_drop_count: got %0d want 1", instr_count); end
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_single_step();
        test_breakpoint();
        test_abort();
        test_reset_mid_run();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
